nyancat_anim_ctrl: RTL and testbench



---
 rtl/nyancat_anim_ctrl.sv | 119 +++++++++++
 tb/tb_nyancat_anim_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/nyancat_anim_ctrl.sv
// Nyancat animation sequencer: finds frame boundaries on vsync, divides the frame rate
// by the selected speed and advances sprite frame / scroll offset during vertical blanking.
module nyancat_anim_ctrl #(
    parameter int NUM_FRAMES       = 12,
    parameter int FRAME_W          = 4,
    parameter int SCROLL_W         = 10,
    parameter int SCROLL_STEP      = 4,
    parameter int BASE_DIV         = 2,
    parameter int VSYNC_ACTIVE_LOW = 1
) (
    input  logic                px_clk,
    input  logic                reset,
    input  logic                vsync,
    input  logic                run_toggle,
    input  logic                step,
    input  logic [1:0]          speed,
    output logic [FRAME_W-1:0]  anim_frame,
    output logic [SCROLL_W-1:0] scroll_x,
    output logic                frame_tick,
    output logic                paused,
    output logic [15:0]         frame_cnt
);
    // state     | meaning
    // RUN       | advancing every div boundaries
    // PAUSED    | frozen, waiting for run_toggle or step
    // STEP_PEND | frozen, one advance owed at the next boundary

    localparam int   DIV_W  = $clog2(8 * BASE_DIV + 1);
    localparam logic VS_INV = (VSYNC_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {RUN, PAUSED, STEP_PEND} state_t;

    state_t             state;
    logic               vs_act;
    logic               vs_prev;
    logic               boundary;
    logic               bnd_q;
    logic               adv_q;
    logic               due;
    logic [DIV_W-1:0]   div;
    logic [DIV_W-1:0]   div_cnt;

    assign vs_act   = vsync ^ VS_INV;
    assign boundary = vs_act & ~vs_prev;
    assign div      = DIV_W'(BASE_DIV) << (2'd3 - speed);
    assign due      = (div_cnt >= div - DIV_W'(1));

    // Decisions are taken on the boundary edge under the current state and applied
    // to the outputs one edge later, so controls never race the boundary.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            state      <= RUN;
            vs_prev    <= 1'b1;
            bnd_q      <= 1'b0;
            adv_q      <= 1'b0;
            div_cnt    <= '0;
            anim_frame <= '0;
            scroll_x   <= '0;
            frame_tick <= 1'b0;
            paused     <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            vs_prev    <= vs_act;
            bnd_q      <= boundary;
            adv_q      <= 1'b0;
            frame_tick <= adv_q;

            if (bnd_q)
                frame_cnt <= frame_cnt + 16'd1;

            if (adv_q) begin
                anim_frame <= (anim_frame == FRAME_W'(NUM_FRAMES - 1)) ? '0 : anim_frame + FRAME_W'(1);
                scroll_x   <= scroll_x + SCROLL_W'(SCROLL_STEP);
            end

            case (state)
                RUN: begin
                    if (boundary) begin
                        if (due) begin
                            adv_q   <= 1'b1;
                            div_cnt <= '0;
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                    if (run_toggle) begin
                        state  <= PAUSED;
                        paused <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (run_toggle) begin
                        state   <= RUN;
                        paused  <= 1'b0;
                        div_cnt <= '0;
                    end else if (step) begin
                        state <= STEP_PEND;
                    end
                end
                STEP_PEND: begin
                    if (boundary)
                        adv_q <= 1'b1;
                    if (run_toggle) begin
                        state   <= RUN;
                        paused  <= 1'b0;
                        div_cnt <= '0;
                    end else if (boundary) begin
                        state <= PAUSED;
                    end
                end
                default: begin
                    state  <= RUN;
                    paused <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nyancat_anim_ctrl.sv
// Directed bench for nyancat_anim_ctrl: active-low and active-high vsync instances
// are driven with the same frames and checked against one reference model.
module tb_nyancat_anim_ctrl;

    logic        px_clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync = 1'b1;
    logic        vsync_hi;
    logic        run_toggle = 1'b0;
    logic        step = 1'b0;
    logic [1:0]  speed = 2'd3;

    logic [3:0]  anim_frame, anim_frame_hi;
    logic [9:0]  scroll_x, scroll_x_hi;
    logic        frame_tick, frame_tick_hi;
    logic        paused, paused_hi;
    logic [15:0] frame_cnt, frame_cnt_hi;

    int n_vec = 0;
    int n_err = 0;

    // model
    localparam int M_RUN = 0, M_PAUSED = 1, M_STEP = 2;
    int exp_frame, exp_scroll, exp_fcnt, exp_state, exp_dcnt;

    assign vsync_hi = ~vsync;

    always #5 px_clk = ~px_clk;

    nyancat_anim_ctrl dut (
        .px_clk(px_clk), .reset(reset), .vsync(vsync),
        .run_toggle(run_toggle), .step(step), .speed(speed),
        .anim_frame(anim_frame), .scroll_x(scroll_x), .frame_tick(frame_tick),
        .paused(paused), .frame_cnt(frame_cnt)
    );

    nyancat_anim_ctrl #(.VSYNC_ACTIVE_LOW(0)) dut_hi (
        .px_clk(px_clk), .reset(reset), .vsync(vsync_hi),
        .run_toggle(run_toggle), .step(step), .speed(speed),
        .anim_frame(anim_frame_hi), .scroll_x(scroll_x_hi), .frame_tick(frame_tick_hi),
        .paused(paused_hi), .frame_cnt(frame_cnt_hi)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_frame = 0; exp_scroll = 0; exp_fcnt = 0; exp_state = M_RUN; exp_dcnt = 0;
    endtask

    // controls act on the state held before the boundary
    task automatic model_ctl(input int st0, input bit tog, input bit stp);
        if (tog) begin
            if (st0 == M_RUN) exp_state = M_PAUSED;
            else begin exp_state = M_RUN; exp_dcnt = 0; end
        end else if (stp && st0 == M_PAUSED) begin
            exp_state = M_STEP;
        end
    endtask

    task automatic do_reset(input logic vs_level);
        @(negedge px_clk);
        reset = 1'b1; vsync = vs_level; run_toggle = 1'b0; step = 1'b0;
        @(negedge px_clk);
        @(negedge px_clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_frame"}, int'(anim_frame), exp_frame);
        chk({tag, "_scroll"}, int'(scroll_x), exp_scroll);
        chk({tag, "_fcnt"}, int'(frame_cnt), exp_fcnt);
        chk({tag, "_paused"}, int'(paused), (exp_state != M_RUN) ? 1 : 0);
        chk({tag, "_frame_hi"}, int'(anim_frame_hi), exp_frame);
        chk({tag, "_scroll_hi"}, int'(scroll_x_hi), exp_scroll);
        chk({tag, "_fcnt_hi"}, int'(frame_cnt_hi), exp_fcnt);
    endtask

    task automatic pulse(input bit tog, input bit stp);
        int st0;
        st0 = exp_state;
        @(negedge px_clk);
        run_toggle = tog; step = stp;
        @(negedge px_clk);
        run_toggle = 1'b0; step = 1'b0;
        model_ctl(st0, tog, stp);
        chk("pulse_paused", int'(paused), (exp_state != M_RUN) ? 1 : 0);
        chk("pulse_tick", int'(frame_tick), 0);
    endtask

    // One 20-cycle video frame with its vsync pulse; controls may ride on the boundary cycle.
    task automatic frame(input string tag, input bit tog, input bit stp);
        int st0, div, adv, nt, nt_hi;
        st0 = exp_state; adv = 0; nt = 0; nt_hi = 0;
        @(negedge px_clk);
        vsync = 1'b0; run_toggle = tog; step = stp;
        for (int k = 1; k < 20; k++) begin
            @(negedge px_clk);
            if (k == 1) begin run_toggle = 1'b0; step = 1'b0; end
            if (k == 2) vsync = 1'b1;
            nt    += int'(frame_tick);
            nt_hi += int'(frame_tick_hi);
        end
        exp_fcnt = (exp_fcnt + 1) % 65536;
        div = 2 << (3 - int'(speed));
        if (st0 == M_RUN) begin
            if (exp_dcnt >= div - 1) begin adv = 1; exp_dcnt = 0; end
            else exp_dcnt++;
        end else if (st0 == M_STEP) begin
            adv = 1; exp_state = M_PAUSED;
        end
        if (adv == 1) begin
            exp_frame  = (exp_frame == 11) ? 0 : exp_frame + 1;
            exp_scroll = (exp_scroll + 4) % 1024;
        end
        model_ctl(st0, tog, stp);
        chk({tag, "_ticks"}, nt, adv);
        chk({tag, "_ticks_hi"}, nt_hi, adv);
        check_outputs(tag);
    endtask

    initial begin
        do_reset(1'b1);
        speed = 2'd3;
        check_outputs("reset");
        chk("reset_tick", int'(frame_tick), 0);

        for (int i = 0; i < 24; i++) frame("spd3", 1'b0, 1'b0);
        chk("spd3_frame_after24", int'(anim_frame), 0);
        for (int i = 0; i < 488; i++) frame("spd3_long", 1'b0, 1'b0);
        chk("wrap_scroll", int'(scroll_x), 0);
        chk("wrap_frame", int'(anim_frame), 4);
        chk("wrap_fcnt", int'(frame_cnt), 512);

        speed = 2'd0;
        for (int i = 0; i < 16; i++) frame("spd0", 1'b0, 1'b0);
        chk("spd0_frame", int'(anim_frame), 5);
        for (int i = 0; i < 9; i++) frame("spd0_part", 1'b0, 1'b0);
        speed = 2'd3;
        frame("spd_change", 1'b0, 1'b0);
        chk("spd_change_frame", int'(anim_frame), 6);
        frame("spd_after1", 1'b0, 1'b0);
        frame("spd_after2", 1'b0, 1'b0);

        pulse(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) frame("paused", 1'b0, 1'b0);
        chk("paused_frame_held", int'(anim_frame), 7);
        pulse(1'b0, 1'b1);
        frame("step", 1'b0, 1'b0);
        chk("step_frame", int'(anim_frame), 8);
        frame("step_once", 1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        frame("resume1", 1'b0, 1'b0);
        frame("resume2", 1'b0, 1'b0);

        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        frame("togstep1", 1'b0, 1'b0);
        frame("togstep2", 1'b0, 1'b0);

        frame("tog_bnd_pre", 1'b0, 1'b0);
        frame("tog_bnd", 1'b1, 1'b0);
        chk("tog_bnd_paused", int'(paused), 1);
        frame("tog_bnd_after", 1'b0, 1'b0);
        pulse(1'b1, 1'b0);

        do_reset(1'b0);
        for (int i = 0; i < 6; i++) @(negedge px_clk);
        chk("vs_held_fcnt", int'(frame_cnt), 0);
        chk("vs_held_fcnt_hi", int'(frame_cnt_hi), 0);
        vsync = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge px_clk);
        chk("vs_released_fcnt", int'(frame_cnt), 0);
        frame("vs_rearm", 1'b0, 1'b0);
        chk("vs_rearm_fcnt", int'(frame_cnt), 1);

        frame("pre_rst", 1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        do_reset(1'b1);
        check_outputs("rst_steppend");
        frame("rst_no_step", 1'b0, 1'b0);
        frame("rst_run", 1'b0, 1'b0);
        chk("rst_run_frame", int'(anim_frame), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
